// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle for alu_seq_core.
// The master side loads operands and consumes results; the slave side is the core.
interface alu_seq_core_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq_core.sv
// Registered W-bit ALU with eight operations, an iterative shift-add multiply,
// {Z,N,C,V} flags and valid/ready handshakes on both sides.
module alu_seq_core #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  alu_seq_core_if.slave bus
);
  localparam int SW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;
  logic [W-1:0]   result_reg;
  logic [3:0]     flags_reg;
  logic [2*W-1:0] mcand_reg;
  logic [2*W-1:0] acc_reg;
  logic [W-1:0]   mplier_reg;
  logic [SW-1:0]  cnt_reg;

  logic [SW-1:0]  shamt;
  logic [W:0]     sum_ext;
  logic [W:0]     diff_ext;
  logic [W:0]     shl_ext;
  logic [W:0]     shr_ext;
  logic [W-1:0]   alu_r;
  logic           alu_c;
  logic           alu_v;
  logic [2*W-1:0] acc_step;

  function automatic logic [3:0] pack_flags(input logic [W-1:0] r, input logic c, input logic v);
    return {(r == '0), r[W-1], c, v};
  endfunction

  assign shamt    = bus.b[SW-1:0];
  assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
  // The extra bit catches the last bit shifted out on either side; it is 0 when shamt==0.
  assign shl_ext  = {1'b0, bus.a} << shamt;
  assign shr_ext  = {bus.a, 1'b0} >> shamt;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_r = sum_ext[W-1:0];
        alu_c = sum_ext[W];
        alu_v = (bus.a[W-1] == bus.b[W-1]) && (alu_r[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        alu_r = diff_ext[W-1:0];
        alu_c = diff_ext[W];
        alu_v = (bus.a[W-1] != bus.b[W-1]) && (alu_r[W-1] != bus.a[W-1]);
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_SHL: begin
        alu_r = shl_ext[W-1:0];
        alu_c = shl_ext[W];
      end
      OP_SHR: begin
        alu_r = shr_ext[W:1];
        alu_c = shr_ext[0];
      end
      default: ;
    endcase
  end

  assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_reg <= 1'b0;
            if (bus.op == OP_MUL) begin
              mcand_reg  <= {{W{1'b0}}, bus.a};
              mplier_reg <= bus.b;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              state_reg  <= BUSY;
            end else begin
              result_reg    <= alu_r;
              flags_reg     <= pack_flags(alu_r, alu_c, alu_v);
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        BUSY: begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          // Last step: the counter wraps back to zero on its own.
          if (cnt_reg == SW'(W - 1)) begin
            result_reg    <= acc_step[W-1:0];
            flags_reg     <= pack_flags(acc_step[W-1:0], |acc_step[2*W-1:W], 1'b0);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (W=8): directed vector table, reset/backpressure
// sequences, and random operations against an arithmetic reference model.
module tb_alu_seq_core;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic ena;
  int   checks;
  int   errors;

  alu_seq_core_if #(.W(W)) bus ();

  alu_seq_core #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
    int         stall;
    int         bp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [3:0] f);
    int ia, ib, sa, sb, s, res, sres;
    bit c, v;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = ib % W;
    c  = 1'b0;
    v  = 1'b0;
    res = 0;
    case (op)
      3'd0: begin res = ia + ib; c = (res > 255); sres = sa + sb; v = (sres > 127) || (sres < -128); end
      3'd1: begin res = ia - ib; c = (ia < ib);   sres = sa - sb; v = (sres > 127) || (sres < -128); end
      3'd2: res = ia & ib;
      3'd3: res = ia | ib;
      3'd4: res = ia ^ ib;
      3'd5: begin res = ia << s; c = (s != 0) && (((ia >> (W - s)) & 1) == 1); end
      3'd6: begin res = ia >> s; c = (s != 0) && (((ia >> (s - 1)) & 1) == 1); end
      default: begin res = ia * ib; c = (res > 255); end
    endcase
    r = res[7:0];
    f = {(r == 8'h00), r[7], c, v};
  endfunction

  // Called and returns at a negedge with the core idle.
  task automatic transact(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r, input logic [3:0] exp_f,
                          input int stall, input int bp);
    int edges, cycles, left, exp_lat;
    bit seen;
    exp_lat = (op == 3'd7) ? W : 0;
    chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    ena          = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    edges  = 0;
    cycles = 0;
    left   = stall;
    seen   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (left > 0 && (i % 2) == 1) begin
        ena = 1'b0;
        left--;
      end else begin
        ena = 1'b1;
        edges++;
      end
      cycles++;
      bus.a = 8'($urandom);
    end
    ena = 1'b1;
    if (!seen) begin
      errors++;
      $display("FAIL %s.timeout: got no out_valid expected out_valid within 100 cycles", name);
      finish_now();
    end
    chk({name, ".latency"}, 32'(edges), 32'(exp_lat));
    chk({name, ".cycles"}, 32'(cycles), 32'(exp_lat + stall));
    chk({name, ".result"}, 32'(bus.result), 32'(exp_r));
    chk({name, ".flags"}, 32'(bus.flags), 32'(exp_f));
    chk({name, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    $display("txn %s op=%0d a=%02h b=%02h -> result=%02h flags=%b lat=%0d", name, op, a, b,
             bus.result, bus.flags, cycles);
    for (int k = 0; k < bp; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      chk({name, ".bp_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, ".bp_hold"}, {20'd0, bus.flags, bus.result}, {20'd0, exp_f, exp_r});
      chk({name, ".bp_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    if (bp > 0) begin
      ena           = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk({name, ".ena_hold"}, 32'(bus.out_valid), 32'd1);
      ena = 1'b1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] mr;
    logic [3:0] mf;
    logic [2:0] rop;
    logic [7:0] ra, rb;
    bit         any_valid;

    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.out_ready = 1'b0;

    vecs.push_back('{"add_carry",  3'd0, 8'hF0, 8'h20, 8'h10, 4'b0010, 0, 0});
    vecs.push_back('{"add_ovf",    3'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 0, 0});
    vecs.push_back('{"sub_ovf",    3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001, 0, 0});
    vecs.push_back('{"sub_zero",   3'd1, 8'h05, 8'h05, 8'h00, 4'b1000, 0, 0});
    vecs.push_back('{"sub_borrow", 3'd1, 8'h03, 8'h05, 8'hFE, 4'b0110, 0, 0});
    vecs.push_back('{"and_zero",   3'd2, 8'hF0, 8'h0F, 8'h00, 4'b1000, 0, 0});
    vecs.push_back('{"or",         3'd3, 8'h80, 8'h01, 8'h81, 4'b0100, 0, 0});
    vecs.push_back('{"xor_bp",     3'd4, 8'hA5, 8'hFF, 8'h5A, 4'b0000, 0, 5});
    vecs.push_back('{"shl1",       3'd5, 8'h81, 8'h01, 8'h02, 4'b0010, 0, 0});
    vecs.push_back('{"shr_s0",     3'd6, 8'h81, 8'h08, 8'h81, 4'b0100, 0, 0});
    vecs.push_back('{"shr1",       3'd6, 8'h81, 8'h01, 8'h40, 4'b0010, 0, 0});
    vecs.push_back('{"mul_20x13",  3'd7, 8'd20, 8'd13, 8'h04, 4'b0010, 0, 0});
    vecs.push_back('{"mul_stall",  3'd7, 8'd20, 8'd13, 8'h04, 4'b0010, 3, 0});
    vecs.push_back('{"mul_3x5",    3'd7, 8'd3,  8'd5,  8'h0F, 4'b0000, 0, 0});
    vecs.push_back('{"mul_ffxff",  3'd7, 8'hFF, 8'hFF, 8'h01, 4'b0010, 0, 2});

    repeat (2) @(negedge clk);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.flags", 32'(bus.flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      transact(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f,
               vecs[i].stall, vecs[i].bp);

    // Reset in the middle of a multiply (counter at 4) must discard the operation.
    bus.in_valid = 1'b1;
    bus.op       = 3'd7;
    bus.a        = 8'd20;
    bus.b        = 8'd13;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.result", 32'(bus.result), 32'd0);
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid = any_valid | bus.out_valid;
    end
    chk("midrst.no_output", 32'(any_valid), 32'd0);
    transact("post_rst_add", 3'd0, 8'd1, 8'd1, 8'd2, 4'b0000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      model(rop, ra, rb, mr, mf);
      transact($sformatf("rand%0d", n), rop, ra, rb, mr, mf,
               (rop == 3'd7) ? int'($urandom_range(0, 3)) : 0, int'($urandom_range(0, 2)));
    end

    finish_now();
  end
endmodule
